// File: rtl/ex_mem_reg.sv
// ---------------------------------------------------------------------------
// ex_mem_reg
//
// Execute-to-memory pipeline register for the 16-bit core. Captures the
// execute-stage result, store data, destination register and control bits
// and presents them to the memory stage. Also holds the architectural Z/V/N
// flag register and a sticky halt indicator.
//
// Priority on each rising edge:
//   1. stall          : hold all state (a simultaneous flush is ignored)
//   2. flush, !ex_valid or halted : load a bubble (valid and controls = 0)
//   3. otherwise      : capture the EX fields, mem_valid = 1
//
// Configuration macro:
//   FLAG_REG_EN  defined   -> flag register with per-opcode update decode
//                undefined -> no flag state, flag_z/v/n tied to 0,
//                             ex_z/v/n unused
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   stall, flush                   pipeline hold / bubble insert
//   ex_valid, ex_op                EX instruction valid and opcode
//   ex_result, ex_store_data       EX datapath values (WIDTH bits)
//   ex_dst_reg                     destination register (REG_BITS bits)
//   ex_mem_read/_write, ex_reg_write, ex_halt   EX control bits
//   ex_z, ex_v, ex_n               flags computed in EX
//   mem_*                          registered copies for the MEM stage
//   flag_z, flag_v, flag_n         architectural flags
//   halted                         sticky: a valid HLT has reached MEM
// ---------------------------------------------------------------------------
module ex_mem_reg #(
    parameter int WIDTH    = 16,
    parameter int REG_BITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                flush,
    input  logic                ex_valid,
    input  logic [3:0]          ex_op,
    input  logic [WIDTH-1:0]    ex_result,
    input  logic [WIDTH-1:0]    ex_store_data,
    input  logic [REG_BITS-1:0] ex_dst_reg,
    input  logic                ex_mem_read,
    input  logic                ex_mem_write,
    input  logic                ex_reg_write,
    input  logic                ex_halt,
    input  logic                ex_z,
    input  logic                ex_v,
    input  logic                ex_n,
    output logic                mem_valid,
    output logic [WIDTH-1:0]    mem_result,
    output logic [WIDTH-1:0]    mem_store_data,
    output logic [REG_BITS-1:0] mem_dst_reg,
    output logic                mem_mem_read,
    output logic                mem_mem_write,
    output logic                mem_reg_write,
    output logic                mem_halt,
    output logic                flag_z,
    output logic                flag_v,
    output logic                flag_n,
    output logic                halted
);

    // Opcodes that touch the flag register.
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRA = 4'b0101;
    localparam logic [3:0] OP_ROR = 4'b0110;

    // A capture is a real instruction entering MEM; everything else that is
    // not a stall becomes a bubble. Once halted, nothing further is admitted.
    logic capture;
    assign capture = !stall && !flush && ex_valid && !halted;

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_valid      <= 1'b0;
            mem_result     <= '0;
            mem_store_data <= '0;
            mem_dst_reg    <= '0;
            mem_mem_read   <= 1'b0;
            mem_mem_write  <= 1'b0;
            mem_reg_write  <= 1'b0;
            mem_halt       <= 1'b0;
            halted         <= 1'b0;
        end else if (!stall) begin
            // Data fields load unconditionally; they are don't-care in a
            // bubble, which keeps the enable off the wide datapath.
            mem_result     <= ex_result;
            mem_store_data <= ex_store_data;
            mem_dst_reg    <= ex_dst_reg;
            mem_valid      <= capture;
            mem_mem_read   <= capture && ex_mem_read;
            mem_mem_write  <= capture && ex_mem_write;
            mem_reg_write  <= capture && ex_reg_write;
            mem_halt       <= capture && ex_halt;
            if (capture && ex_halt) begin
                halted <= 1'b1;
            end
        end
    end

`ifdef FLAG_REG_EN
    // Per-opcode flag update enables.
    logic upd_zvn;
    logic upd_z;

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        upd_zvn = 1'b0;
        upd_z   = 1'b0;
        unique case (ex_op)
            OP_ADD, OP_SUB:                 upd_zvn = 1'b1;
            OP_XOR, OP_SLL, OP_SRA, OP_ROR: upd_z   = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_z <= 1'b0;
            flag_v <= 1'b0;
            flag_n <= 1'b0;
        end else if (capture) begin
            if (upd_zvn || upd_z) begin
                flag_z <= ex_z;
            end
            if (upd_zvn) begin
                flag_v <= ex_v;
                flag_n <= ex_n;
            end
        end
    end
`else
    assign flag_z = 1'b0;
    assign flag_v = 1'b0;
    assign flag_n = 1'b0;

    // Flag inputs have no destination in this build.
    logic unused_flags;
    assign unused_flags = &{1'b0, ex_z, ex_v, ex_n};
`endif

endmodule

// File: tb/tb_ex_mem_reg.sv
// ---------------------------------------------------------------------------
// tb_ex_mem_reg
//
// Self-checking bench for ex_mem_reg. A table of sequential vectors (inputs
// plus expected outputs after the following rising edge) covers captures,
// per-opcode flag behaviour, stall/flush priority and bubbles. Hand-written
// sequences cover halt stickiness and asynchronous reset. Expected flags are
// architectural values; without FLAG_REG_EN they are expected to read 0.
// ---------------------------------------------------------------------------
module tb_ex_mem_reg;

    localparam int WIDTH    = 16;
    localparam int REG_BITS = 4;

    logic                clk;
    logic                rst;
    logic                stall;
    logic                flush;
    logic                ex_valid;
    logic [3:0]          ex_op;
    logic [WIDTH-1:0]    ex_result;
    logic [WIDTH-1:0]    ex_store_data;
    logic [REG_BITS-1:0] ex_dst_reg;
    logic                ex_mem_read;
    logic                ex_mem_write;
    logic                ex_reg_write;
    logic                ex_halt;
    logic                ex_z;
    logic                ex_v;
    logic                ex_n;
    logic                mem_valid;
    logic [WIDTH-1:0]    mem_result;
    logic [WIDTH-1:0]    mem_store_data;
    logic [REG_BITS-1:0] mem_dst_reg;
    logic                mem_mem_read;
    logic                mem_mem_write;
    logic                mem_reg_write;
    logic                mem_halt;
    logic                flag_z;
    logic                flag_v;
    logic                flag_n;
    logic                halted;

    ex_mem_reg #(.WIDTH(WIDTH), .REG_BITS(REG_BITS)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .flush         (flush),
        .ex_valid      (ex_valid),
        .ex_op         (ex_op),
        .ex_result     (ex_result),
        .ex_store_data (ex_store_data),
        .ex_dst_reg    (ex_dst_reg),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_write  (ex_mem_write),
        .ex_reg_write  (ex_reg_write),
        .ex_halt       (ex_halt),
        .ex_z          (ex_z),
        .ex_v          (ex_v),
        .ex_n          (ex_n),
        .mem_valid     (mem_valid),
        .mem_result    (mem_result),
        .mem_store_data(mem_store_data),
        .mem_dst_reg   (mem_dst_reg),
        .mem_mem_read  (mem_mem_read),
        .mem_mem_write (mem_mem_write),
        .mem_reg_write (mem_reg_write),
        .mem_halt      (mem_halt),
        .flag_z        (flag_z),
        .flag_v        (flag_v),
        .flag_n        (flag_n),
        .halted        (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        flush;
        logic        valid;
        logic [3:0]  op;
        logic [15:0] result;
        logic [15:0] store;
        logic [3:0]  dst;
        logic        rd;
        logic        wr;
        logic        rw;
        logic        ht;
        logic        z;
        logic        v;
        logic        n;
    } in_t;

    typedef struct {
        logic        mv;
        logic [15:0] result;
        logic [15:0] store;
        logic [3:0]  dst;
        logic        rd;
        logic        wr;
        logic        rw;
        logic        ht;
        logic        fz;
        logic        fv;
        logic        fn;
        logic        halted;
    } out_t;

    typedef struct {
        in_t  i;
        out_t o;
        bit   chk_data;
    } vec_t;

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input out_t e, input bit chk_data);
        logic ez, ev, en;
`ifdef FLAG_REG_EN
        ez = e.fz; ev = e.fv; en = e.fn;
`else
        ez = 1'b0; ev = 1'b0; en = 1'b0;
`endif
        check({tag, ".mem_valid"},     {31'b0, mem_valid},     {31'b0, e.mv});
        if (chk_data) begin
            check({tag, ".mem_result"},     {16'b0, mem_result},     {16'b0, e.result});
            check({tag, ".mem_store_data"}, {16'b0, mem_store_data}, {16'b0, e.store});
            check({tag, ".mem_dst_reg"},    {28'b0, mem_dst_reg},    {28'b0, e.dst});
        end
        check({tag, ".mem_mem_read"},  {31'b0, mem_mem_read},  {31'b0, e.rd});
        check({tag, ".mem_mem_write"}, {31'b0, mem_mem_write}, {31'b0, e.wr});
        check({tag, ".mem_reg_write"}, {31'b0, mem_reg_write}, {31'b0, e.rw});
        check({tag, ".mem_halt"},      {31'b0, mem_halt},      {31'b0, e.ht});
        check({tag, ".flags"},         {29'b0, flag_z, flag_v, flag_n}, {29'b0, ez, ev, en});
        check({tag, ".halted"},        {31'b0, halted},        {31'b0, e.halted});
    endtask

    task automatic drive(input in_t i);
        stall         = i.stall;
        flush         = i.flush;
        ex_valid      = i.valid;
        ex_op         = i.op;
        ex_result     = i.result;
        ex_store_data = i.store;
        ex_dst_reg    = i.dst;
        ex_mem_read   = i.rd;
        ex_mem_write  = i.wr;
        ex_reg_write  = i.rw;
        ex_halt       = i.ht;
        ex_z          = i.z;
        ex_v          = i.v;
        ex_n          = i.n;
    endtask

    // Drive on the falling edge, let one rising edge pass, sample 1 ns later.
    task automatic step(input in_t i);
        @(negedge clk);
        drive(i);
        @(posedge clk);
        #1;
    endtask

    localparam in_t IDLE = '{1'b0, 1'b0, 1'b0, 4'h0, 16'h0, 16'h0, 4'h0,
                             1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam out_t ZERO = '{1'b0, 16'h0, 16'h0, 4'h0, 1'b0, 1'b0, 1'b0,
                              1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    vec_t vec [17];

    initial begin
        in_t  ti;
        out_t to;

        // Fields: stall flush valid op result store dst rd wr rw ht z v n
        //      -> mv result store dst rd wr rw ht fz fv fn halted
        // ADD capture.
        vec[0]  = '{'{0,0,1,4'h0,16'h8000,16'h0000,4'h3,0,0,1,0,0,1,1},
                    '{1,16'h8000,16'h0000,4'h3,0,0,1,0,0,1,1,0}, 1};
        // SUB updates all three flags.
        vec[1]  = '{'{0,0,1,4'h1,16'h0000,16'h1111,4'h5,0,0,1,0,1,1,1},
                    '{1,16'h0000,16'h1111,4'h5,0,0,1,0,1,1,1,0}, 1};
        // RED: flags untouched.
        vec[2]  = '{'{0,0,1,4'h3,16'hFFF9,16'h2222,4'h6,0,0,1,0,0,0,0},
                    '{1,16'hFFF9,16'h2222,4'h6,0,0,1,0,1,1,1,0}, 1};
        // XOR: Z only.
        vec[3]  = '{'{0,0,1,4'h2,16'h1234,16'h3333,4'h2,0,0,1,0,0,0,0},
                    '{1,16'h1234,16'h3333,4'h2,0,0,1,0,0,1,1,0}, 1};
        // SLL: Z only.
        vec[4]  = '{'{0,0,1,4'h4,16'h0000,16'h4444,4'h4,0,0,1,0,1,0,0},
                    '{1,16'h0000,16'h4444,4'h4,0,0,1,0,1,1,1,0}, 1};
        // LW (op 1000): no flag change, mem_read passes.
        vec[5]  = '{'{0,0,1,4'h8,16'h0040,16'h5555,4'h7,1,0,1,0,0,0,0},
                    '{1,16'h0040,16'h5555,4'h7,1,0,1,0,1,1,1,0}, 1};
        // SW (op 1001) with store data.
        vec[6]  = '{'{0,0,1,4'h9,16'h0042,16'hBEEF,4'h0,0,1,0,0,0,0,0},
                    '{1,16'h0042,16'hBEEF,4'h0,0,1,0,0,1,1,1,0}, 1};
        // Stall + flush for two cycles: hold.
        vec[7]  = '{'{1,1,1,4'h0,16'hAAAA,16'h5A5A,4'h9,0,0,1,0,0,0,0},
                    '{1,16'h0042,16'hBEEF,4'h0,0,1,0,0,1,1,1,0}, 1};
        vec[8]  = vec[7];
        // Stall released with flush high: bubble, flags unchanged.
        vec[9]  = '{'{0,1,1,4'h0,16'hAAAA,16'h5A5A,4'h9,0,0,1,0,0,0,0},
                    '{0,16'h0,16'h0,4'h0,0,0,0,0,1,1,1,0}, 0};
        // ex_valid=0: bubble, flags unchanged.
        vec[10] = '{'{0,0,0,4'h0,16'h7777,16'h0,4'h1,1,1,1,1,0,0,0},
                    '{0,16'h0,16'h0,4'h0,0,0,0,0,1,1,1,0}, 0};
        // ADD clearing flags.
        vec[11] = '{'{0,0,1,4'h0,16'h0007,16'h0000,4'h1,0,0,1,0,0,0,0},
                    '{1,16'h0007,16'h0000,4'h1,0,0,1,0,0,0,0,0}, 1};
        // PADDSB (0111): no flag change.
        vec[12] = '{'{0,0,1,4'h7,16'h7F80,16'h0000,4'h8,0,0,1,0,1,1,1},
                    '{1,16'h7F80,16'h0000,4'h8,0,0,1,0,0,0,0,0}, 1};
        // Opcode 1111: no flag change.
        vec[13] = '{'{0,0,1,4'hF,16'hFFFF,16'hFFFF,4'hF,0,0,0,0,1,1,1},
                    '{1,16'hFFFF,16'hFFFF,4'hF,0,0,0,0,0,0,0,0}, 1};
        // SRA: Z only.
        vec[14] = '{'{0,0,1,4'h5,16'h0000,16'h0001,4'hA,0,0,1,0,1,1,1},
                    '{1,16'h0000,16'h0001,4'hA,0,0,1,0,1,0,0,0}, 1};
        // ROR: Z only.
        vec[15] = '{'{0,0,1,4'h6,16'h8001,16'h0002,4'hB,0,0,1,0,0,1,1},
                    '{1,16'h8001,16'h0002,4'hB,0,0,1,0,0,0,0,0}, 1};
        // Plain stall on a valid ADD: hold.
        vec[16] = '{'{1,0,1,4'h0,16'h1111,16'h2222,4'hC,0,0,1,0,1,1,1},
                    '{1,16'h8001,16'h0002,4'hB,0,0,1,0,0,0,0,0}, 1};

        // Reset state.
        drive(IDLE);
        rst = 1'b1;
        #12;
        check_all("reset", ZERO, 1);
        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < 17; k++) begin
            step(vec[k].i);
            check_all($sformatf("vec%0d", k), vec[k].o, vec[k].chk_data);
        end

        // Halt: a valid HLT reaches MEM, then halted sticks and blocks captures.
        ti = IDLE; ti.valid = 1; ti.op = 4'hF; ti.ht = 1; ti.result = 16'h0F0F; ti.dst = 4'h2;
        step(ti);
        to = ZERO; to.mv = 1; to.ht = 1; to.halted = 1; to.result = 16'h0F0F; to.dst = 4'h2;
        check_all("halt_capture", to, 1);

        ti = IDLE; ti.valid = 1; ti.op = 4'h0; ti.rw = 1; ti.z = 1; ti.v = 1; ti.n = 1;
        step(ti);
        to = ZERO; to.halted = 1;
        check_all("halt_blocks_add", to, 0);
        step(ti);
        check_all("halt_sticky", to, 0);

        // Asynchronous reset clears halted without a clock edge.
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_all("rst_clears_halt", ZERO, 1);
        @(negedge clk);
        rst = 1'b0;

        // Valid SW in MEM, then reset between edges.
        ti = IDLE; ti.valid = 1; ti.op = 4'h9; ti.wr = 1; ti.store = 16'hBEEF;
        ti.result = 16'h0100; ti.dst = 4'h6;
        step(ti);
        to = ZERO; to.mv = 1; to.wr = 1; to.store = 16'hBEEF; to.result = 16'h0100; to.dst = 4'h6;
        check_all("sw_before_rst", to, 1);
        #2 rst = 1'b1;
        #1;
        check_all("async_rst", ZERO, 1);
        // Held through clock edges while rst stays high, despite valid inputs.
        repeat (2) @(posedge clk);
        #1;
        check_all("rst_held", ZERO, 1);
        @(negedge clk);
        rst = 1'b0;

        // First capture after release follows the normal rules.
        ti = IDLE; ti.valid = 1; ti.op = 4'h0; ti.rw = 1; ti.result = 16'h8000;
        ti.dst = 4'h3; ti.v = 1; ti.n = 1;
        step(ti);
        to = ZERO; to.mv = 1; to.rw = 1; to.result = 16'h8000; to.dst = 4'h3; to.fv = 1; to.fn = 1;
        check_all("post_rst_add", to, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/ex_mem_reg.md
# ex_mem_reg

Execute-to-memory pipeline register for the 16-bit core. It captures the execute-stage result (ALU, RED, PADDSB, shifter), store data, destination register and control bits, and presents them to the memory stage. It also owns the architectural Z/V/N flag register, with per-opcode update rules, and a sticky halt indicator. It supports stall (hold), flush (bubble insert) and asynchronous reset.

## Interface
- WIDTH, 16, datapath width of result and store data
- REG_BITS, 4, destination register index width
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high
- stall  in  1  hold every register this cycle
- flush  in  1  load a bubble instead of EX contents
- ex_valid  in  1  EX holds a real instruction
- ex_op  in  4  opcode of EX instruction
- ex_result  in  WIDTH  execute result
- ex_store_data  in  WIDTH  data for SW
- ex_dst_reg  in  REG_BITS  destination register
- ex_mem_read / ex_mem_write / ex_reg_write / ex_halt  in  1 each  control bits
- ex_z / ex_v / ex_n  in  1 each  flags computed in EX
- mem_valid  out  1  MEM holds a real instruction
- mem_result / mem_store_data  out  WIDTH  registered copies
- mem_dst_reg  out  REG_BITS  registered copy
- mem_mem_read / mem_mem_write / mem_reg_write / mem_halt  out  1 each  registered, forced 0 for bubbles
- flag_z / flag_v / flag_n  out  1 each  architectural flags
- halted  out  1  sticky; a valid HLT has reached MEM

## Operation
- Per rising edge, the first matching rule applies:
  1. stall=1: hold all state. A flush in the same cycle is ignored.
  2. flush=1, ex_valid=0, or halted=1: load a bubble. mem_valid and all control outputs go to 0. Data fields may be loaded but are don't-care.
  3. Otherwise: capture all ex_* fields, and mem_valid=1.
- Flag update happens only on a rule-3 capture. The decode uses ex_op:
  - ADD 0000, SUB 0001: update Z, V, N.
  - XOR 0010, SLL 0100, SRA 0101, ROR 0110: update Z only.
  - RED 0011, PADDSB 0111, and all opcodes ≥1000: no flag change.
- halted sets on the edge where a rule-3 capture has ex_halt=1. It stays 1 until rst.
- The block does no arithmetic. Data passes through unmodified and with full width.

## Timing
- Latency: exactly 1 cycle from EX inputs to mem_* outputs.
- The new flags are visible on the cycle after capture, together with the mem_* fields of the same instruction.
- Reset values while rst=1, held regardless of clk: all outputs 0, i.e. mem_valid=0, data=16'h0000, dst=0, controls=0, flags=0, halted=0.
- Reset mid-stream: state clears immediately. The first capture after release follows the normal rules.
- Stall released together with flush high: a bubble loads on that edge.

## Configuration
- FLAG_REG_EN defined: the flag register and the opcode decode exist as described.
- FLAG_REG_EN undefined:
  - no flag state is instantiated;
  - flag_z, flag_v and flag_n are tied to 0;
  - ex_z, ex_v and ex_n are unused;
  - all other behaviour is unchanged.

## Test plan
- ADD capture: ex_valid=1, ex_op=0000, result=16'h8000, z=0, v=1, n=1, reg_write=1, dst=3 → next cycle mem_valid=1, mem_result=16'h8000, mem_dst_reg=3, flags Z/V/N = 0/1/1.
- RED isolation: flags preset 1/1/1, then capture ex_op=0011, result=16'hFFF9, z=0, v=0, n=0 → mem_result=16'hFFF9, flags remain 1/1/1. Then XOR with z=0 → flags 0/1/1.
- Stall vs flush: a valid instruction sits in MEM; assert stall=1 and flush=1 for 2 cycles → outputs unchanged. Then stall=0 with flush=1 → mem_valid=0, mem_mem_write=0, flags unchanged.
- Halt: capture ex_halt=1, ex_valid=1 → mem_halt=1, halted=1 next cycle. A following valid ADD → bubble (mem_valid=0), flags unchanged, halted stays 1.
- Async reset: assert rst between clock edges while MEM holds a valid SW with store_data=16'hBEEF → all outputs 0 before the next edge, halted=0.
- FLAG_REG_EN undefined: repeat the ADD case → flags stay 0/0/0, datapath outputs identical.
